// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU arbiter: FSM states, ALU function
// codes and the datapath width.
package alu_arb_pkg;

  localparam int ALU_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SLL   = 4'b0101;
  localparam logic [3:0] ALU_SRL   = 4'b0110;
  localparam logic [3:0] ALU_SRA   = 4'b0111;
  localparam logic [3:0] ALU_SLT   = 4'b1000;
  localparam logic [3:0] ALU_SLTU  = 4'b1001;
  localparam logic [3:0] ALU_NOR   = 4'b1010;
  localparam logic [3:0] ALU_PASSA = 4'b1011;
  localparam logic [3:0] ALU_PASSB = 4'b1100;
  localparam logic [3:0] ALU_EQ    = 4'b1101;
  localparam logic [3:0] ALU_LTZ   = 4'b1110;
  localparam logic [3:0] ALU_NEZ   = 4'b1111;

endpackage

// File: rtl/alu_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after the
// pointer, wrapping, as a one-hot vector plus a binary index.
module alu_rr_pick #(
  parameter int NREQ = 2,
  parameter int IDW  = 3
) (
  input  logic [NREQ-1:0] i_valid,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IDW-1:0]  o_idx,
  output logic            o_any
);

  // Offset i is visited before offset i+1, so the first hit is closest to ptr.
  always_comb begin
    int tgt;
    tgt     = 0;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      tgt = int'(i_ptr) + i;
      if (tgt >= NREQ) tgt = tgt - NREQ;
      for (int j = 0; j < NREQ; j++) begin
        if (!o_any && (j == tgt) && i_valid[j]) begin
          o_any      = 1'b1;
          o_grant[j] = 1'b1;
          o_idx      = IDW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between NREQ requesters using
// round-robin arbitration. Optional requester locking: ALU_ARB_LOCK_EN.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [ALU_W*NREQ-1:0] req_a,
  input  logic [ALU_W*NREQ-1:0] req_b,
  input  logic [5*NREQ-1:0]     req_shamt,
  input  logic [4*NREQ-1:0]     req_func,
`ifdef ALU_ARB_LOCK_EN
  input  logic [NREQ-1:0]       req_lock,
`endif
  output logic [ALU_W-1:0]      alu_a,
  output logic [ALU_W-1:0]      alu_b,
  output logic [4:0]            alu_shamt,
  output logic [3:0]            alu_func,
  input  logic [ALU_W-1:0]      alu_out,
  input  logic                  alu_zero,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [ALU_W-1:0]      rsp_data,
  output logic                  rsp_zero
);

  arb_state_t       r_state, w_next_state;
  logic [IDW-1:0]   r_ptr, r_rsp_id, w_gnt_idx, w_ptr_next;
  logic [NREQ-1:0]  w_pick_valid, w_grant;
  logic             w_any, w_idle, w_grant_fire, w_rsp_done, w_ptr_adv;
  logic [ALU_W-1:0] r_alu_a, r_alu_b, r_rsp_data, w_sel_a, w_sel_b;
  logic [4:0]       r_alu_shamt, w_sel_shamt;
  logic [3:0]       r_alu_func, w_sel_func;
  logic             r_rsp_zero;

  // A grant while reset is held would be a handshake nobody completes.
  assign w_idle       = (r_state == IDLE) && rst_n;
  assign w_grant_fire = w_idle && w_any;
  assign w_rsp_done   = (r_state == RESP) && rsp_ready;
  assign w_ptr_next   = (r_rsp_id == IDW'(NREQ - 1)) ? '0 : r_rsp_id + IDW'(1);

`ifdef ALU_ARB_LOCK_EN
  logic            r_locked, r_cur_lock;
  logic [NREQ-1:0] r_lock_mask;

  assign w_pick_valid = r_locked ? (req_valid & r_lock_mask) : req_valid;
  assign w_ptr_adv    = w_rsp_done && !r_cur_lock;

  // A locked grant pins arbitration to its owner until an unlocked one completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_locked    <= 1'b0;
      r_cur_lock  <= 1'b0;
      r_lock_mask <= '0;
    end else begin
      if (w_grant_fire) begin
        r_cur_lock  <= |(req_lock & w_grant);
        r_lock_mask <= w_grant;
        if (|(req_lock & w_grant)) r_locked <= 1'b1;
      end
      if (w_ptr_adv) r_locked <= 1'b0;
    end
  end
`else
  assign w_pick_valid = req_valid;
  assign w_ptr_adv    = w_rsp_done;
`endif

  alu_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .i_valid (w_pick_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_gnt_idx),
    .o_any   (w_any)
  );

  always_comb begin
    w_sel_a     = '0;
    w_sel_b     = '0;
    w_sel_shamt = '0;
    w_sel_func  = ALU_ADD;
    for (int k = 0; k < NREQ; k++) begin
      if (w_grant[k]) begin
        w_sel_a     = req_a[k*ALU_W +: ALU_W];
        w_sel_b     = req_b[k*ALU_W +: ALU_W];
        w_sel_shamt = req_shamt[k*5 +: 5];
        w_sel_func  = req_func[k*4 +: 4];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    req_ready    = '0;
    rsp_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = w_idle ? w_grant : '0;
        if (w_any) w_next_state = EXEC;
      end
      EXEC: w_next_state = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_shamt <= '0;
      r_alu_func  <= ALU_ADD;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
      r_rsp_zero  <= 1'b0;
      r_ptr       <= '0;
    end else begin
      if (w_grant_fire) begin
        r_alu_a     <= w_sel_a;
        r_alu_b     <= w_sel_b;
        r_alu_shamt <= w_sel_shamt;
        r_alu_func  <= w_sel_func;
        r_rsp_id    <= w_gnt_idx;
      end
      if (r_state == EXEC) begin
        r_rsp_data <= alu_out;
        r_rsp_zero <= alu_zero;
      end
      if (w_ptr_adv) r_ptr <= w_ptr_next;
    end
  end

  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_shamt = r_alu_shamt;
  assign alu_func  = r_alu_func;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign rsp_zero  = r_rsp_zero;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: transaction-level reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_alu_arbiter;

  localparam int NREQ = 2;
  localparam int IDW  = 3;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [32*NREQ-1:0] req_a;
  logic [32*NREQ-1:0] req_b;
  logic [5*NREQ-1:0] req_shamt;
  logic [4*NREQ-1:0] req_func;
  logic [NREQ-1:0]   req_lock;
  logic [31:0]       alu_a, alu_b, alu_out, rsp_data;
  logic [4:0]        alu_shamt;
  logic [3:0]        alu_func;
  logic              alu_zero, rsp_valid, rsp_ready, rsp_zero;
  logic [IDW-1:0]    rsp_id;

  int nTests = 0;
  int nFail  = 0;

  // Reference behaviour of the external ALU, one line per function code.
  function automatic logic [31:0] aluRef(input logic [31:0] a, input logic [31:0] b,
                                         input logic [4:0] sh, input logic [3:0] fn);
    case (fn)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return a << sh;
      4'd6:  return a >> sh;
      4'd7:  return $unsigned($signed(a) >>> sh);
      4'd8:  return {31'd0, $signed(a) < $signed(b)};
      4'd9:  return {31'd0, a < b};
      4'd10: return ~(a | b);
      4'd11: return a;
      4'd12: return b;
      4'd13: return {31'd0, a == b};
      4'd14: return {31'd0, a[31]};
      default: return {31'd0, a != 32'd0};
    endcase
  endfunction

  assign alu_out  = aluRef(alu_a, alu_b, alu_shamt, alu_func);
  assign alu_zero = (alu_out == 32'd0);

  alu_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_shamt (req_shamt),
    .req_func  (req_func),
`ifdef ALU_ARB_LOCK_EN
    .req_lock  (req_lock),
`endif
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_shamt (alu_shamt),
    .alu_func  (alu_func),
    .alu_out   (alu_out),
    .alu_zero  (alu_zero),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_zero  (rsp_zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nTests++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int k, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] sh, input logic [3:0] fn);
    for (int j = 0; j < NREQ; j++) begin
      if (j == k) begin
        req_a[j*32 +: 32]  = a;
        req_b[j*32 +: 32]  = b;
        req_shamt[j*5 +: 5] = sh;
        req_func[j*4 +: 4]  = fn;
        req_valid[j]        = 1'b1;
      end
    end
  endtask

  task automatic waitGrant(input int k);
    logic found;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      #1;
      if (req_ready == (NREQ'(1) << k)) found = 1'b1;
      else stepCycle();
    end
    checkOutput("grant_wait", {31'd0, found}, 32'd1);
  endtask

  task automatic waitResp();
    logic found;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (rsp_valid) found = 1'b1;
      else stepCycle();
    end
    checkOutput("rsp_wait", {31'd0, found}, 32'd1);
  endtask

  task automatic pulseReset();
    rst_n = 1'b0;
    stepCycle();
    stepCycle();
    rst_n = 1'b1;
    stepCycle();
  endtask

  // Transaction-level model: an operation is in flight from its grant; its
  // response is due two cycles after the grant and retires on rsp_ready.
  int          mPtr, mId, mAge, mLockId;
  logic        mInflight, mLocked, mCurLock, mZero;
  logic [31:0] mA, mB, mData;
  logic [4:0]  mSh;
  logic [3:0]  mFunc;

  task automatic modelReset();
    mPtr = 0; mId = 0; mAge = 0; mLockId = 0;
    mInflight = 1'b0; mLocked = 1'b0; mCurLock = 1'b0; mZero = 1'b0;
    mA = '0; mB = '0; mData = '0; mSh = '0; mFunc = 4'b0000;
  endtask

  function automatic int modelPick();
    int pick;
    pick = -1;
    for (int i = 0; i < NREQ; i++)
      for (int k = 0; k < NREQ; k++)
        if (pick < 0 && k == (mPtr + i) % NREQ && req_valid[k] && (!mLocked || k == mLockId))
          pick = k;
    return pick;
  endfunction

  always @(negedge clk) begin
    int g;
    logic [NREQ-1:0] expReady;
    logic rspDue;
    if (!rst_n) modelReset();
    g = -1;
    expReady = '0;
    if (rst_n && !mInflight) g = modelPick();
    for (int k = 0; k < NREQ; k++) if (k == g) expReady[k] = 1'b1;
    rspDue = mInflight && (mAge >= 2);
    checkOutput("cmp_req_ready", 32'(req_ready), 32'(expReady));
    checkOutput("cmp_rsp_valid", {31'd0, rsp_valid}, {31'd0, rspDue});
    checkOutput("cmp_rsp_id", 32'(rsp_id), mId);
    checkOutput("cmp_alu_a", alu_a, mA);
    checkOutput("cmp_alu_b", alu_b, mB);
    checkOutput("cmp_alu_shamt", 32'(alu_shamt), 32'(mSh));
    checkOutput("cmp_alu_func", 32'(alu_func), 32'(mFunc));
    if (!rst_n || rspDue) begin
      checkOutput("cmp_rsp_data", rsp_data, mData);
      checkOutput("cmp_rsp_zero", {31'd0, rsp_zero}, {31'd0, mZero});
    end
    if (rst_n) begin
      if (mInflight) begin
        if (mAge >= 2) begin
          if (rsp_ready) begin
            mInflight = 1'b0;
            if (!mCurLock) begin
              mPtr = (mId + 1) % NREQ;
              mLocked = 1'b0;
            end
          end
        end else begin
          mAge++;
        end
      end else if (g >= 0) begin
        mInflight = 1'b1;
        mAge = 1;
        mId = g;
        for (int k = 0; k < NREQ; k++) begin
          if (k == g) begin
            mA = req_a[k*32 +: 32];
            mB = req_b[k*32 +: 32];
            mSh = req_shamt[k*5 +: 5];
            mFunc = req_func[k*4 +: 4];
            mCurLock = req_lock[k];
          end
        end
        mData = aluRef(mA, mB, mSh, mFunc);
        mZero = (mData == 32'd0);
        if (mCurLock) begin
          mLocked = 1'b1;
          mLockId = g;
        end
      end
    end
  end

  initial begin
    int grants[8];
    int ids[8];
    int expAlt[4];
    int nG, nR, cnt0;
    logic unlockNext;
    expAlt = '{0, 1, 0, 1};

    rst_n = 1'b0;
    req_valid = 2'b11;
    req_a = '0; req_b = '0; req_shamt = '0; req_func = '0;
    req_lock = '0;
    rsp_ready = 1'b1;
    stepCycle();
    stepCycle();
    checkOutput("reset_req_ready", 32'(req_ready), 32'd0);
    checkOutput("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("reset_alu_func", 32'(alu_func), 32'd0);
    checkOutput("reset_rsp_data", rsp_data, 32'd0);
    req_valid = '0;
    rst_n = 1'b1;
    stepCycle();

    // Single request from requester 1: 7 - 5.
    applyStimulus(1, 32'd7, 32'd5, 5'd0, 4'b0001);
    waitGrant(1);
    checkOutput("single_ready", 32'(req_ready), 32'd2);
    stepCycle();
    req_valid = '0;
    checkOutput("single_t1_valid", {31'd0, rsp_valid}, 32'd0);
    stepCycle();
    checkOutput("single_t2_valid", {31'd0, rsp_valid}, 32'd1);
    checkOutput("single_data", rsp_data, 32'd2);
    checkOutput("single_zero", {31'd0, rsp_zero}, 32'd0);
    checkOutput("single_id", 32'(rsp_id), 32'd1);
    stepCycle();

    // Contention: both requesters hold valid; grants must alternate.
    applyStimulus(0, 32'd10, 32'd1, 5'd0, 4'b0000);
    applyStimulus(1, 32'd20, 32'd2, 5'd0, 4'b0000);
    nG = 0; nR = 0;
    for (int c = 0; c < 60 && (nG < 4 || nR < 4); c++) begin
      #1;
      if (req_ready != 0 && nG < 8) begin
        grants[nG] = req_ready[1] ? 1 : 0;
        nG++;
      end
      if (rsp_valid && rsp_ready && nR < 8) begin
        ids[nR] = int'(rsp_id);
        nR++;
      end
      stepCycle();
      if (nG >= 4) req_valid = '0;
    end
    checkOutput("cont_grant_count", nG, 32'd4);
    checkOutput("cont_rsp_count", nR, 32'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput("cont_grant_order", grants[i], expAlt[i]);
      checkOutput("cont_rsp_order", ids[i], expAlt[i]);
    end

    // Backpressure: response held for five cycles, accepted on the sixth.
    rsp_ready = 1'b0;
    applyStimulus(0, 32'h10, 32'h0, 5'd0, 4'b1011);
    waitGrant(0);
    stepCycle();
    req_valid = '0;
    applyStimulus(1, 32'hAAAA, 32'h5555, 5'd3, 4'b0100);
    waitResp();
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput("bp_valid", {31'd0, rsp_valid}, 32'd1);
      checkOutput("bp_data", rsp_data, 32'h10);
      checkOutput("bp_id", 32'(rsp_id), 32'd0);
      checkOutput("bp_no_grant", 32'(req_ready), 32'd0);
      stepCycle();
    end
    rsp_ready = 1'b1;
    #1;
    checkOutput("bp_accept_valid", {31'd0, rsp_valid}, 32'd1);
    checkOutput("bp_accept_data", rsp_data, 32'h10);
    stepCycle();
    #1;
    checkOutput("bp_next_grant", 32'(req_ready), 32'd2);
    stepCycle();
    req_valid = '0;
    waitResp();
    checkOutput("bp_xor_data", rsp_data, 32'hFFFF);
    stepCycle();

    // Zero flag.
    applyStimulus(0, 32'h1234, 32'h1234, 5'd0, 4'b0001);
    waitGrant(0);
    stepCycle();
    req_valid = '0;
    waitResp();
    checkOutput("zero_data", rsp_data, 32'd0);
    checkOutput("zero_flag", {31'd0, rsp_zero}, 32'd1);
    stepCycle();

    // Reset during EXEC drops the operation and clears the pointer.
    applyStimulus(1, 32'd3, 32'd4, 5'd2, 4'b0101);
    waitGrant(1);
    stepCycle();
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("rst_alu_func", 32'(alu_func), 32'd0);
    checkOutput("rst_alu_a", alu_a, 32'd0);
    stepCycle();
    stepCycle();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      stepCycle();
      checkOutput("rst_no_stale", {31'd0, rsp_valid}, 32'd0);
    end
    applyStimulus(0, 32'd100, 32'd1, 5'd0, 4'b0001);
    applyStimulus(1, 32'd200, 32'd2, 5'd0, 4'b0001);
    #1;
    checkOutput("rst_ptr_zero", 32'(req_ready), 32'd1);
    stepCycle();
    req_valid[0] = 1'b0;
    waitResp();
    checkOutput("rst_after_data", rsp_data, 32'd99);
    stepCycle();
    waitGrant(1);
    stepCycle();
    req_valid = '0;
    waitResp();
    stepCycle();

`ifdef ALU_ARB_LOCK_EN
    // Lock: requester 0 keeps the ALU until it issues an unlocked request.
    begin
      int expLock[4];
      expLock = '{0, 0, 0, 1};
      pulseReset();
      req_lock = 2'b01;
      applyStimulus(0, 32'd1, 32'd2, 5'd0, 4'b0000);
      applyStimulus(1, 32'd3, 32'd4, 5'd0, 4'b0000);
      nG = 0; cnt0 = 0; unlockNext = 1'b0;
      for (int c = 0; c < 60 && nG < 4; c++) begin
        #1;
        if (req_ready != 0) begin
          grants[nG] = req_ready[1] ? 1 : 0;
          nG++;
          if (!req_ready[1]) begin
            cnt0++;
            if (cnt0 == 2) unlockNext = 1'b1;
          end
        end
        stepCycle();
        if (unlockNext) begin
          req_lock = '0;
          unlockNext = 1'b0;
        end
        if (nG >= 4) req_valid = '0;
      end
      checkOutput("lock_grant_count", nG, 32'd4);
      for (int i = 0; i < 4; i++) checkOutput("lock_grant_order", grants[i], expLock[i]);
      waitResp();
      stepCycle();
    end
`endif

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one ALU instance between `NREQ` requesters, such as the core execute stage, a debug port and an address-generation helper. Each requester uses a valid/ready handshake. Round-robin arbitration picks one requester, the block drives the ALU operands from registers, and it captures the result. The result is returned on a shared response channel tagged with the requester index. The block sits between the requesters and the external ALU; the ALU stays a separate combinational instance.

## Interface
- `NREQ`, default 2: number of requesters, legal range 2..8.
- `IDW`, default 3: width of `rsp_id`; must satisfy 2^IDW >= NREQ.
- `clk`  in  1: the single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `req_valid`  in  NREQ: request pending, one bit per requester.
- `req_ready`  out  NREQ: grant; a one-hot pulse, high for exactly one cycle.
- `req_a`  in  32*NREQ: operand a; requester k uses bits [32k+31:32k].
- `req_b`  in  32*NREQ: operand b, same slicing as `req_a`.
- `req_shamt`  in  5*NREQ: shift amount, 5-bit slices.
- `req_func`  in  4*NREQ: ALU function code, 4-bit slices.
- `alu_a`, `alu_b`  out  32: registered operands to the ALU.
- `alu_shamt`  out  5: registered shift amount.
- `alu_func`  out  4: registered function code.
- `alu_out`  in  32: ALU result.
- `alu_zero`  in  1: ALU zero flag.
- `rsp_valid`  out  1: response available.
- `rsp_ready`  in  1: consumer accepts the response.
- `rsp_id`  out  IDW: index of the requester that owns the response.
- `rsp_data`  out  32: captured ALU result.
- `rsp_zero`  out  1: captured zero flag.

## Operation
- The FSM has three states:
  - IDLE → EXEC when any `req_valid` is high.
  - EXEC → RESP unconditionally.
  - RESP → IDLE when `rsp_ready` is high; otherwise it stays in RESP.
- Granting happens only in IDLE:
  - The winner g is the first set `req_valid` bit at or after round-robin pointer `ptr`, wrapping from NREQ-1 to 0.
  - `req_ready[g]` is high combinationally that cycle; that cycle is the handshake.
  - The slices of requester g are latched into `alu_a`, `alu_b`, `alu_shamt` and `alu_func`, and g is latched into `rsp_id`.
- EXEC: `alu_out` and `alu_zero` are captured into `rsp_data` and `rsp_zero`.
- RESP:
  - `rsp_valid` is high.
  - `rsp_data`, `rsp_zero` and `rsp_id` are held stable until `rsp_ready`.
  - `ptr` becomes (g+1) mod NREQ at the `rsp_ready` handshake.
- `req_ready` is all zeros outside IDLE. Requesters hold `req_valid` and their operands until granted.
- Operands are never modified by this block. All 16 function codes pass through unchanged, including 4'b1011 (pass a).
- A deasserted `req_valid` bit is never granted, even if it was high in an earlier cycle.

## Timing
- Reset values:
  - state = IDLE; `ptr` = 0.
  - `alu_a`, `alu_b`, `rsp_data` = 0; `alu_shamt` = 0.
  - `alu_func` = 4'b0000 (ADD), so the ALU never sees an undefined code.
  - `rsp_id` = 0; `rsp_zero` = 0; `rsp_valid` = 0; `req_ready` = 0.
- Latency: grant in cycle T, `rsp_valid` high from cycle T+2.
- Throughput: at most one operation per 3 cycles with `rsp_ready` tied high.
- Backpressure: RESP holds indefinitely and no grants are issued meanwhile.
- Reset asserted mid-operation returns immediately to reset values. The in-flight response is dropped, and a requester granted before reset must not expect a response.
- Simultaneous requests: exactly one grant per IDLE cycle, chosen by `ptr` order.
- Starvation bound: a continuously requesting port is granted within NREQ operations.

## Configuration
- `ALU_ARB_LOCK_EN` defined:
  - Adds input `req_lock` (NREQ bits).
  - If `req_lock[g]` is high at grant, the block enters a locked mode and `ptr` is not advanced.
  - In locked mode only requester g can be granted in the following IDLE states, so the other requesters wait.
  - The lock is released after the first completed response for a grant where `req_lock[g]` was low.
- Undefined: the port is absent and arbitration is pure round-robin.

## Structure
- Shared package `alu_arb_pkg`:
  - FSM state enum: IDLE, EXEC, RESP.
  - ALU function-code constants: `ALU_ADD`=4'b0000 through `ALU_NEZ`=4'b1111.
  - `ALU_W`=32.
- Sub-module `alu_rr_pick`:
  - Combinational round-robin picker taking `req_valid` and `ptr` inputs.
  - Produces a one-hot grant vector and a binary grant index.
  - Parameterised by NREQ.

## Test plan
- Single request: requester 1 with a=7, b=5, func=0001. `req_ready[1]` pulses in cycle T; `rsp_valid` at T+2 with data=2, zero=0, id=1.
- Contention: both requesters hold `req_valid` from reset with func 0000. Grants alternate 0,1,0,1 over four operations, and `rsp_id` follows the same order.
- Backpressure: `rsp_ready` low for 5 cycles with data=0x10 held. The response stays stable, no `req_ready` pulses, and it is accepted on the 6th cycle.
- Zero flag: a=b=0x1234, func 0001. Data=0, zero=1.
- Reset mid-EXEC: `rst_n` low in the EXEC cycle. Next edge shows `rsp_valid`=0, `alu_func`=0000 and `ptr`=0, and no stale response appears afterwards.
- With `ALU_ARB_LOCK_EN` defined: requester 0 locks while both request. Requester 0 is granted three times in a row, its third request has lock low and it is unlocked, then requester 1 is granted.
